// File: rtl/game_flow_ctrl.sv
// Match sequencer for the collision controller: idle/attract, serve delay, play,
// pause, post-point freeze and game-over hold, driven by two buttons and a frame tick.
module game_flow_ctrl #(
  parameter int SERVE_TICKS = 120,
  parameter int POINT_TICKS = 60,
  parameter int OVER_TICKS  = 300,
  parameter int TMR_W       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       wall_col,
  input  logic       lossA,
  input  logic       lossB,
  output logic       game_en,
  output logic       round_rst_n,
  output logic       gmv,
  output logic [2:0] state,
  output logic [1:0] winner,
  output logic       point_pulse
);

  // state | meaning
  // IDLE  | attract screen, scores held cleared, waits for start
  // SERVE | ball held at centre for SERVE_TICKS frames
  // PLAY  | collision controller running
  // PAUSE | field frozen until the next pause press
  // POINT | field frozen for POINT_TICKS frames after a point
  // OVER  | game-over screen held for OVER_TICKS frames
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SERVE = 3'd1;
  localparam logic [2:0] PLAY  = 3'd2;
  localparam logic [2:0] PAUSE = 3'd3;
  localparam logic [2:0] POINT = 3'd4;
  localparam logic [2:0] OVER  = 3'd5;

  localparam logic [TMR_W-1:0] SERVE_LD = TMR_W'(SERVE_TICKS - 1);
  localparam logic [TMR_W-1:0] POINT_LD = TMR_W'(POINT_TICKS - 1);
  localparam logic [TMR_W-1:0] OVER_LD  = TMR_W'(OVER_TICKS - 1);

  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [1:0]       winner_q, winner_d;
  logic             point_pulse_q, point_pulse_d;
  logic             game_en_q, game_en_d;
  logic             round_rst_n_q, round_rst_n_d;
  logic             gmv_q, gmv_d;
  logic             start_s1_q, start_s2_q, start_s3_q;
  logic             pause_s1_q, pause_s2_q, pause_s3_q;
  logic             wall_col_d_q;

  logic start_edge, pause_edge, wall_edge;

  assign start_edge = start_s2_q & ~start_s3_q;
  assign pause_edge = pause_s2_q & ~pause_s3_q;
  assign wall_edge  = wall_col & ~wall_col_d_q;

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    winner_d      = winner_q;
    point_pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (start_edge) begin
          state_d  = SERVE;
          winner_d = 2'b00;
        end
      end
      SERVE: begin
        if (frame_tick) begin
          if (timer_q == '0) state_d = PLAY;
          else               timer_d = timer_q - 1'b1;
        end
      end
      PLAY: begin
        timer_d = '0;
        if (lossA | lossB) begin
          state_d  = OVER;
          winner_d = {lossB, lossA};
        end else if (wall_edge) begin
          state_d       = POINT;
          point_pulse_d = 1'b1;
        end else if (pause_edge) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        timer_d = '0;
        if (pause_edge) state_d = PLAY;
      end
      POINT: begin
        if (frame_tick) begin
          if (timer_q == '0) state_d = SERVE;
          else               timer_d = timer_q - 1'b1;
        end
      end
      OVER: begin
        if (frame_tick) begin
          if (timer_q == '0) state_d = IDLE;
          else               timer_d = timer_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase

    // Any transition reloads the timer for the state being entered.
    if (state_d != state_q) begin
      case (state_d)
        SERVE:   timer_d = SERVE_LD;
        POINT:   timer_d = POINT_LD;
        OVER:    timer_d = OVER_LD;
        default: timer_d = '0;
      endcase
    end
  end

  always_comb begin
    game_en_d     = 1'b0;
    round_rst_n_d = 1'b1;
    gmv_d         = 1'b0;
    case (state_d)
      IDLE: begin
        game_en_d     = 1'b1;
        round_rst_n_d = 1'b0;
        gmv_d         = 1'b1;
      end
      SERVE: begin
        game_en_d     = 1'b1;
        round_rst_n_d = 1'b0;
      end
      PLAY:    game_en_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      winner_q      <= 2'b00;
      point_pulse_q <= 1'b0;
      game_en_q     <= 1'b1;
      round_rst_n_q <= 1'b0;
      gmv_q         <= 1'b1;
      start_s1_q    <= 1'b0;
      start_s2_q    <= 1'b0;
      start_s3_q    <= 1'b0;
      pause_s1_q    <= 1'b0;
      pause_s2_q    <= 1'b0;
      pause_s3_q    <= 1'b0;
      wall_col_d_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      winner_q      <= winner_d;
      point_pulse_q <= point_pulse_d;
      game_en_q     <= game_en_d;
      round_rst_n_q <= round_rst_n_d;
      gmv_q         <= gmv_d;
      start_s1_q    <= start_btn;
      start_s2_q    <= start_s1_q;
      start_s3_q    <= start_s2_q;
      pause_s1_q    <= pause_btn;
      pause_s2_q    <= pause_s1_q;
      pause_s3_q    <= pause_s2_q;
      wall_col_d_q  <= wall_col;
    end
  end

  assign state       = state_q;
  assign winner      = winner_q;
  assign point_pulse = point_pulse_q;
  assign game_en     = game_en_q;
  assign round_rst_n = round_rst_n_q;
  assign gmv         = gmv_q;

endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
- Top-level match sequencer, directly upstream of the collision controller.
- Drives that controller's game_en, rst_n and gmv inputs.
- Consumes its wall_col, lossA and lossB outputs.
- Sequences idle/attract, serve delay, play, pause, post-point hold and game-over hold from two player buttons and a frame tick.

Parameters:
- SERVE_TICKS, 120: frame ticks the ball is held at centre before play starts.
- POINT_TICKS, 60: frame ticks the field is frozen after a point.
- OVER_TICKS, 300: frame ticks the game-over screen is held before returning to idle.
- TMR_W, 9: timer width; must satisfy 2^TMR_W > max(all *_TICKS).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-cycle pulse per video frame; timer advance enable
- start_btn  in  1  raw start button, active high, asynchronous to clk
- pause_btn  in  1  raw pause button, active high, asynchronous to clk
- wall_col  in  1  point-scored flag from collision controller (level)
- lossA  in  1  player A reached max score (level)
- lossB  in  1  player B reached max score (level)
- game_en  out  1  collision controller enable
- round_rst_n  out  1  collision controller rst_n (active-low round reset)
- gmv  out  1  new-game flag; with round_rst_n low, clears scores
- state  out  3  current state code
- winner  out  2  latched game result
- point_pulse  out  1  one-cycle pulse on each point

Behaviour:
- Reset is asynchronous, active-low: clk and rst_n only; polarity and synchronicity fixed.
- While rst_n is low:
  - state=IDLE, game_en=1, round_rst_n=0, gmv=1.
  - winner=2'b00, point_pulse=0, timer=0.
  - Sync/edge registers = 0.
- Reset mid-operation aborts any state and timer immediately.
- Buttons: each passes a 2-flop synchronizer, then a rising-edge detector (sync2 & ~sync3).
  - A press is acted on 3 clk edges after the raw input rises.
  - A held button yields a single edge.
- wall_col: rising-edge detected (wall_col & ~wall_col_d), so a level held high across states never retriggers.
- All outputs are registered and decoded from the next state; they change on the same edge as state.
- Timer:
  - Loaded to (N-1) on entry to a timed state.
  - Decrements only on frame_tick.
  - The state exits on the frame_tick that sees timer==0, so N ticks are spent in the state.
- States (code: game_en / round_rst_n / gmv):
  - IDLE (0: 1/0/1): scores continuously cleared. start edge -> SERVE. winner is held until a start edge clears it.
  - SERVE (1: 1/0/0): ball/paddles held at defaults, scores kept. Timer SERVE_TICKS expires -> PLAY.
  - PLAY (2: 1/1/0): evaluated each cycle, priority high to low:
    - (lossA|lossB) -> OVER; winner <= {lossB,lossA} (2'b11 if both the same cycle).
    - wall_col edge -> POINT; point_pulse=1 for one cycle.
    - pause edge -> PAUSE.
    - start edge is ignored.
  - PAUSE (3: 0/1/0): everything frozen. pause edge -> PLAY. Timer, loss and wall_col inputs ignored (the wall_col edge detector still tracks).
  - POINT (4: 0/1/0): frozen for POINT_TICKS -> SERVE. Buttons ignored.
  - OVER (5: 0/1/0): frozen for OVER_TICKS -> IDLE. Buttons ignored.
- Codes 6 and 7 are illegal and return to IDLE on the next edge.
- A frame_tick and an exit condition in the same cycle: the exit condition wins; the timer is reloaded for the new state.
- Widths:
  - timer is TMR_W bits and never underflows; it holds at 0 outside timed states.
  - winner changes only on the PLAY->OVER transition or the IDLE start edge (cleared to 0).

Test Plan:
- Reset, then release → game_en=1, round_rst_n=0, gmv=1, state=0, winner=0. With SERVE_TICKS=3, pulse start_btn for 5 cycles → state=1 exactly 3 edges after the rise, with one transition only. After 3 frame_ticks → state=2, round_rst_n=1, gmv=0.
- In PLAY, raise wall_col and hold it → point_pulse high for exactly one cycle, state=4, game_en=0. With POINT_TICKS=2, after 2 ticks → state=1. The still-high wall_col does not cause a second point once back in PLAY.
- In PLAY, raise lossB and wall_col in the same cycle → state=5, winner=2'b10, no point_pulse. With OVER_TICKS=4, after 4 ticks → state=0, gmv=1, winner still 2'b10. A start edge then clears winner to 0.
- In PLAY, pause edge → state=3, game_en=0. lossA asserted while paused → no change. Second pause edge → state=2, then OVER with winner=2'b01.
- In SERVE with timer=1, frame_tick asserted and rst_n dropped mid-cycle → outputs go to reset values immediately, without waiting for a clk edge. After release → state=0.
- Force state register to 6 → state=0 on the next clk.
